// File: rtl/toggle_to_pulse.sv
// Toggle-encoded event to handshaked single-cycle pulses, with a pending-event counter.
// Define T2P_PULSE_GAP_EN to force at least two idle cycles between pulses (FIRE -> GAP -> IDLE).
module toggle_to_pulse #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tog_in,
  input  logic             ready,
  output logic             pulse,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] PEND_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   primed_r;
  logic [2:0]             prime_cnt_r;
  logic [CNT_W-1:0]       pending_r;
  logic [CNT_W-1:0]       pending_nxt_s;
  logic                   overflow_r;
  logic                   ovf_set_s;
  logic                   pulse_r;
  state_t                 state_r;
  logic                   s_last_s;
  logic                   event_s;
  logic                   enter_fire_s;

  assign s_last_s = sync_r[SYNC_STAGES-1];
  assign event_s  = primed_r && (s_last_s != prev_r);

  // Synchronizer chain and edge-detect history
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], tog_in};
      prev_r <= s_last_s;
    end
  end

  // Suppress detection until the chain has flushed, so a stale level after reset is not an event
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prime_cnt_r <= 3'd0;
      primed_r    <= 1'b0;
    end else if (!primed_r) begin
      if (prime_cnt_r == PRIME_LAST) begin
        primed_r <= 1'b1;
      end else begin
        prime_cnt_r <= prime_cnt_r + 3'd1;
      end
    end else begin
      prime_cnt_r <= prime_cnt_r;
      primed_r    <= primed_r;
    end
  end

  // Edges that enter FIRE consume one pending event
  always_comb begin
    enter_fire_s = 1'b0;
`ifdef T2P_PULSE_GAP_EN
    if ((state_r == IDLE) && (pending_r != PEND_ZERO) && ready) begin
      enter_fire_s = 1'b1;
    end else begin
      enter_fire_s = 1'b0;
    end
`else
    if (((state_r == IDLE) || (state_r == FIRE)) && (pending_r != PEND_ZERO) && ready) begin
      enter_fire_s = 1'b1;
    end else begin
      enter_fire_s = 1'b0;
    end
`endif
  end

  // Pending counter next value; saturation drops the event and flags overflow
  always_comb begin
    pending_nxt_s = pending_r;
    ovf_set_s     = 1'b0;
    case ({event_s, enter_fire_s})
      2'b10: begin
        if (pending_r == PEND_MAX) begin
          ovf_set_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r + PEND_ONE;
        end
      end
      2'b01:   pending_nxt_s = pending_r - PEND_ONE;
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Pending counter and sticky overflow
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending_r  <= PEND_ZERO;
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_r | ovf_set_s;
    end
  end

  // Pulse FSM; pulse is registered alongside the state so it is high exactly in FIRE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
      pulse_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enter_fire_s) begin
            state_r <= FIRE;
            pulse_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
          end
        end
        FIRE: begin
`ifdef T2P_PULSE_GAP_EN
          state_r <= GAP;
          pulse_r <= 1'b0;
`else
          if (enter_fire_s) begin
            state_r <= FIRE;
            pulse_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
          end
`endif
        end
        GAP: begin
          state_r <= IDLE;
          pulse_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          pulse_r <= 1'b0;
        end
      endcase
    end
  end

  assign pulse    = pulse_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;
  assign busy     = (pending_r != PEND_ZERO) || (state_r != IDLE);

endmodule

// File: tb/tb_toggle_to_pulse.sv
// Directed self-checking bench for toggle_to_pulse; a second instance with CNT_W=2 covers saturation.
module tb_toggle_to_pulse;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       tog_in = 1'b0;
  logic       ready = 1'b1;
  logic       pulse, overflow, busy;
  logic [3:0] pending;
  logic       pulse2, overflow2, busy2;
  logic [1:0] pending2;
  int         checks = 0;
  int         fails = 0;

  toggle_to_pulse #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .tog_in(tog_in), .ready(ready),
    .pulse(pulse), .pending(pending), .overflow(overflow), .busy(busy)
  );

  toggle_to_pulse #(.SYNC_STAGES(2), .CNT_W(2)) dut_small (
    .Clock(Clock), .Reset(Reset), .tog_in(tog_in), .ready(ready),
    .pulse(pulse2), .pending(pending2), .overflow(overflow2), .busy(busy2)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    repeat (6) tick();
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      tog_in = ~tog_in;
      repeat (4) tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; tog_in = 1'b0; ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({pulse, pending, overflow, busy} !== 7'b0) begin
      $display("FAIL reset_outputs got p=%b pend=%0d ovf=%b busy=%b exp all 0", pulse, pending, overflow, busy);
      fails++;
    end
    // tog_in already high when reset releases must not look like an event
    tog_in = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pulse !== 1'b0 || pending !== 4'd0) begin
        $display("FAIL prime_suppress cyc %0d got p=%b pend=%0d exp p=0 pend=0", i, pulse, pending);
        fails++;
      end
    end
  endtask

  task automatic test_latency();
    logic [4:0] ep;
    logic [4:0] eb;
    logic [4:0] epend1;
    ep = 5'b01000; eb = 5'b01100; epend1 = 5'b00100;
    do_reset();
    tog_in = ~tog_in;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pulse !== ep[i] || busy !== eb[i] || pending !== {3'b000, epend1[i]}) begin
        $display("FAIL latency edge k+%0d got p=%b busy=%b pend=%0d exp p=%b busy=%b pend=%0d",
                 i, pulse, busy, pending, ep[i], eb[i], epend1[i]);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen;
    logic [15:0] exp_seen;
`ifdef T2P_PULSE_GAP_EN
    exp_seen = 16'b0001_0010_0100_1001;
`else
    exp_seen = 16'b0000_0000_0001_1111;
`endif
    do_reset();
    ready = 1'b0;
    toggles(5);
    checks++;
    if (pending !== 4'd5 || pulse !== 1'b0) begin
      $display("FAIL stall_pending got pend=%0d p=%b exp pend=5 p=0", pending, pulse);
      fails++;
    end
    ready = 1'b1;
    seen = 16'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seen[i] = pulse;
    end
    checks++;
    if (seen !== exp_seen) begin
      $display("FAIL b2b_pattern got %b exp %b", seen, exp_seen);
      fails++;
    end
    checks++;
    if (pending !== 4'd0 || busy !== 1'b0) begin
      $display("FAIL b2b_drain got pend=%0d busy=%b exp pend=0 busy=0", pending, busy);
      fails++;
    end
  endtask

  task automatic test_overflow();
    int n1;
    int n2;
    do_reset();
    ready = 1'b0;
    toggles(4);
    checks++;
    if (pending2 !== 2'd3 || overflow2 !== 1'b1) begin
      $display("FAIL ovf_small got pend=%0d ovf=%b exp pend=3 ovf=1", pending2, overflow2);
      fails++;
    end
    checks++;
    if (pending !== 4'd4 || overflow !== 1'b0) begin
      $display("FAIL ovf_wide got pend=%0d ovf=%b exp pend=4 ovf=0", pending, overflow);
      fails++;
    end
    ready = 1'b1;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      n1 += int'(pulse);
      n2 += int'(pulse2);
    end
    checks++;
    if (n2 != 3 || overflow2 !== 1'b1) begin
      $display("FAIL ovf_drain_small got pulses=%0d ovf=%b exp pulses=3 ovf=1", n2, overflow2);
      fails++;
    end
    checks++;
    if (n1 != 4) begin
      $display("FAIL ovf_drain_wide got pulses=%0d exp 4", n1);
      fails++;
    end
    do_reset();
    checks++;
    if (overflow2 !== 1'b0) begin
      $display("FAIL ovf_clear got ovf=%b exp 0", overflow2);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    ready = 1'b0;
    toggles(1);
    // next event is detected two edges after this change, on the same edge ready enters FIRE
    tog_in = ~tog_in;
    tick();
    tick();
    ready = 1'b1;
    tick();
    checks++;
    if (pulse !== 1'b1 || pending !== 4'd1) begin
      $display("FAIL simul_entry got p=%b pend=%0d exp p=1 pend=1", pulse, pending);
      fails++;
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(pulse);
    end
    checks++;
    if (n != 1 || pending !== 4'd0) begin
      $display("FAIL simul_second got later_pulses=%0d pend=%0d exp 1 and 0", n, pending);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    ready = 1'b0;
    toggles(3);
    ready = 1'b1;
    tick();
    checks++;
    if (pulse !== 1'b1 || pending !== 4'd2) begin
      $display("FAIL midrst_setup got p=%b pend=%0d exp p=1 pend=2", pulse, pending);
      fails++;
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (pulse !== 1'b0 || pending !== 4'd0 || busy !== 1'b0) begin
      $display("FAIL midrst_clear got p=%b pend=%0d busy=%b exp 0 0 0", pulse, pending, busy);
      fails++;
    end
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n += int'(pulse);
    end
    checks++;
    if (n != 0 || pending !== 4'd0) begin
      $display("FAIL midrst_after got pulses=%0d pend=%0d exp 0 0", n, pending);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/toggle_to_pulse.md
TOGGLE_TO_PULSE -- requirements
Module: toggle_to_pulse

Interface
REQ-001 Parameters SHALL be:
- SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
- CNT_W, default 4, width of the pending-event counter.

REQ-002 Ports SHALL be:
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous, active-high.
- tog_in  in  1  toggle-encoded event from the far domain; each level change is one event.
- ready  in  1  downstream may accept a pulse this cycle.
- pulse  out  1  registered single-cycle event pulse.
- pending  out  CNT_W  count of events detected but not yet pulsed.
- overflow  out  1  sticky; an event was lost at counter saturation.
- busy  out  1  high when pending != 0 or FSM != IDLE.

Function
REQ-003 tog_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (s_last) SHALL be used.
REQ-004 A register prev SHALL hold the previous s_last; an event SHALL be detected when the block is primed and s_last != prev.
REQ-005 Priming: after Reset deasserts, prev SHALL copy s_last with no event detection for SYNC_STAGES+1 cycles; primed SHALL then be set until the next Reset.
REQ-006 The FSM SHALL have states IDLE, FIRE and GAP; pulse SHALL be 1 only in FIRE.
REQ-007 IDLE -> FIRE SHALL occur when pending != 0 and ready = 1; otherwise the FSM SHALL stay in IDLE.
REQ-008 FIRE SHALL last exactly one cycle; its successor is defined in REQ-016/017.
REQ-009 pending SHALL decrement by 1 at each clock edge that enters FIRE.
REQ-010 pending SHALL increment by 1 at each clock edge where an event is detected.
REQ-011 A simultaneous increment and decrement SHALL leave pending unchanged.
REQ-012 At pending = 2^CNT_W-1, an event without a simultaneous decrement SHALL leave pending unchanged and set overflow.
REQ-013 ready low SHALL only stall: pending SHALL be retained and no event SHALL be dropped except under REQ-012.
REQ-014 Latency: with SYNC_STAGES=2, primed, pending=0, FSM in IDLE and ready=1, a tog_in change sampled at edge k SHALL give pulse=1 from edge k+3 to edge k+4.
REQ-015 Each tog_in change SHALL produce exactly one pulse, provided tog_in is stable for at least SYNC_STAGES+1 cycles between changes.

Configuration
REQ-016 With macro T2P_PULSE_GAP_EN defined:
- FIRE -> GAP unconditionally.
- GAP -> IDLE unconditionally, with pulse=0.
- Consecutive pulses SHALL therefore be separated by at least 2 low cycles.
- Throughput SHALL be at most 1 pulse per 3 cycles.
REQ-017 With T2P_PULSE_GAP_EN undefined:
- GAP SHALL be unreachable.
- FIRE -> FIRE when pending (after the REQ-009 decrement) != 0 and ready = 1; otherwise FIRE -> IDLE.
- Back-to-back pulses SHALL be allowed; throughput SHALL be up to 1 pulse per cycle.

Reset
REQ-018 While Reset = 1, at every rising Clock edge the following SHALL be cleared to 0:
- the synchronizer chain, prev and primed;
- the priming counter;
- the FSM, which SHALL go to IDLE.
REQ-019 The output reset values SHALL be pulse=0, pending=0, overflow=0 and busy=0.
REQ-020 Reset asserted mid-pulse or with pending != 0 SHALL discard all events; no pulse SHALL appear for pre-reset events.
REQ-021 Reset SHALL clear overflow; nothing else SHALL clear overflow.

Verification
REQ-022 Default params, gap undefined, ready=1, Reset released, tog_in held 1 from reset -> no pulse, pending stays 0 (priming suppresses the spurious edge).
REQ-023 Primed, tog_in 0->1 at edge 10 -> pulse=1 only during edge13-edge14, pending 1 for one cycle, busy high then low.
REQ-024 ready=0, tog_in toggles 5 times 4 cycles apart, then ready=1:
- pending SHALL read 5 before ready rises;
- gap undefined: 5 consecutive pulse cycles;
- T2P_PULSE_GAP_EN defined: 5 pulses, each 3 cycles apart.
REQ-025 CNT_W=2, ready=0, 4 toggles -> pending=3 and overflow=1; then ready=1 -> 3 pulses, overflow stays 1 until Reset.
REQ-026 An event detected on the same edge as a FIRE entry, with pending=1 -> pending stays 1 and a second pulse follows.
REQ-027 Reset asserted during FIRE with pending=2 -> pulse=0 and pending=0 next cycle; no further pulses.
